// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: difference = a + ~b + 1, one bit per clock, LSB first.
// A start/done handshake wraps a single gate-level full-adder cell.

module serial_subtractor_fa (
  input  wire x,
  input  wire y,
  input  wire cin,
  output wire s,
  output wire cout
);
  wire xy_s;
  wire gen_s;
  wire prop_s;

  xor g_xy   (xy_s, x, y);
  xor g_sum  (s, xy_s, cin);
  and g_gen  (gen_s, x, y);
  and g_prop (prop_s, xy_s, cin);
  or  g_cout (cout, gen_s, prop_s);
endmodule

module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             carryout,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] res_r;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;
  logic             a_msb_r;
  logic             b_msb_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] diff_r;
  logic             cout_r;
  logic             ovf_r;
  logic             b_inv_s;
  logic             sum_s;
  logic             carry_nxt_s;
  logic             load_s;
  logic             step_s;
  logic             last_s;

  assign b_inv_s = ~b_sh_r[0];

  serial_subtractor_fa u_fa (
    .x    (a_sh_r[0]),
    .y    (b_inv_s),
    .cin  (carry_r),
    .s    (sum_s),
    .cout (carry_nxt_s)
  );

  // Next-state and datapath control decode.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    step_s      = 1'b0;
    last_s      = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          load_s      = 1'b1;
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (cnt_r == LAST) begin
          last_s      = 1'b1;
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, shift registers and registered result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      a_sh_r  <= {WIDTH{1'b0}};
      b_sh_r  <= {WIDTH{1'b0}};
      res_r   <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      carry_r <= 1'b1;
      a_msb_r <= 1'b0;
      b_msb_r <= 1'b0;
      diff_r  <= {WIDTH{1'b0}};
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == RUN);
      done_r  <= (state_nxt_s == DONE);
      if (load_s) begin
        a_sh_r  <= a;
        b_sh_r  <= b;
        a_msb_r <= a[WIDTH-1];
        b_msb_r <= b[WIDTH-1];
        cnt_r   <= {CW{1'b0}};
        carry_r <= 1'b1;
      end else if (step_s) begin
        a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
        b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
        res_r   <= {sum_s, res_r[WIDTH-1:1]};
        carry_r <= carry_nxt_s;
        cnt_r   <= cnt_r + CW'(1);
      end
      // The final bit goes straight into the output register so the result is valid with done.
      if (last_s) begin
        diff_r <= {sum_s, res_r[WIDTH-1:1]};
        cout_r <= carry_nxt_s;
        ovf_r  <= (a_msb_r ^ b_msb_r) & (a_msb_r ^ sum_s);
      end
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign difference = diff_r;
  assign carryout   = cout_r;
  assign overflow   = ovf_r;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and sweep bench for serial_subtractor at WIDTH=4 and WIDTH=8,
// with a result queue filled at start and drained on done.

module tb_serial_subtractor;
  logic       clk = 1'b0;
  logic       reset;
  logic       start4, start8;
  logic [3:0] a4, b4, diff4;
  logic [7:0] a8, b8, diff8;
  logic       busy4, done4, co4, ov4;
  logic       busy8, done8, co8, ov8;

  int tests = 0;
  int fails = 0;
  logic [5:0] q4[$];
  logic [9:0] q8[$];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(4)) u4 (
    .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .difference(diff4), .carryout(co4), .overflow(ov4)
  );

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .difference(diff8), .carryout(co8), .overflow(ov8)
  );

  function automatic logic [5:0] ref4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] d;
    d = x - y;
    return {(x[3] ^ y[3]) & (x[3] ^ d[3]), (x >= y), d};
  endfunction

  function automatic logic [9:0] ref8(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] d;
    d = x - y;
    return {(x[7] ^ y[7]) & (x[7] ^ d[7]), (x >= y), d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one WIDTH=4 request and returns in its DONE cycle.
  task automatic op4(input logic [3:0] x, input logic [3:0] y, input bit keep);
    logic [5:0] prev;
    logic [5:0] e;
    a4 = x;
    b4 = y;
    start4 = 1'b1;
    q4.push_back(ref4(x, y));
    prev = {ov4, co4, diff4};
    tick();
    if (!keep) start4 = 1'b0;
    a4 = 4'($urandom);
    b4 = 4'($urandom);
    for (int i = 1; i <= 4; i++) begin
      check("busy4_run", {30'd0, busy4, done4}, 32'h2);
      check("hold4_run", {26'd0, ov4, co4, diff4}, {26'd0, prev});
      tick();
    end
    check("done4_pulse", {30'd0, busy4, done4}, 32'h1);
    e = q4.pop_front();
    check("res4", {26'd0, ov4, co4, diff4}, {26'd0, e});
  endtask

  task automatic op8(input logic [7:0] x, input logic [7:0] y);
    int n;
    logic [9:0] e;
    a8 = x;
    b8 = y;
    start8 = 1'b1;
    q8.push_back(ref8(x, y));
    tick();
    start8 = 1'b0;
    a8 = ~x;
    b8 = ~y;
    n = 1;
    while (done8 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("lat8", n, 32'd9);
    e = q8.pop_front();
    check("res8", {22'd0, ov8, co8, diff8}, {22'd0, e});
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    start4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
    start8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
    tick();
    tick();
    reset = 1'b0;
    check("reset4", {25'd0, busy4, done4, ov4, co4, diff4}, 32'h0);
    check("reset8", {21'd0, busy8, done8, ov8, co8, diff8}, 32'h0);

    op4(4'd5, 4'd3, 1'b0);
    check("val_5m3", {26'd0, ov4, co4, diff4}, 32'b01_0010);
    tick();
    check("idle4", {30'd0, busy4, done4}, 32'h0);
    check("hold4_idle", {26'd0, ov4, co4, diff4}, 32'b01_0010);

    op4(4'd3, 4'd5, 1'b0);
    check("val_3m5", {26'd0, ov4, co4, diff4}, 32'b00_1110);
    tick();
    op4(4'b0111, 4'b1111, 1'b0);
    check("val_7mm1", {26'd0, ov4, co4, diff4}, 32'b10_1000);
    tick();
    op4(4'b1000, 4'b0001, 1'b0);
    check("val_m8m1", {26'd0, ov4, co4, diff4}, 32'b11_0111);
    tick();

    // Back-to-back with start held high throughout.
    op4(4'd9, 4'd9, 1'b1);
    check("val_9m9", {26'd0, ov4, co4, diff4}, 32'b01_0000);
    op4(4'd0, 4'd1, 1'b0);
    check("val_0m1", {26'd0, ov4, co4, diff4}, 32'b00_1111);
    tick();
    check("idle4_b2b", {30'd0, busy4, done4}, 32'h0);

    // Reset during RUN cycle 2 aborts the operation.
    a4 = 4'd6; b4 = 4'd2; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort4", {25'd0, busy4, done4, ov4, co4, diff4}, 32'h0);
    for (int i = 0; i < 6; i++) begin
      check("abort4_nodone", {31'd0, done4}, 32'h0);
      tick();
    end
    op4(4'd6, 4'd2, 1'b0);
    check("val_6m2", {26'd0, ov4, co4, diff4}, 32'b01_0100);
    tick();

    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        op4(4'(x), 4'(y), 1'b0);
        tick();
      end
    end

    op8(8'h00, 8'h00);
    op8(8'hFF, 8'h01);
    op8(8'h80, 8'h01);
    op8(8'h7F, 8'h80);
    for (int i = 0; i < 40; i++) begin
      op8(8'($urandom), 8'($urandom));
    end

    check("q4_empty", q4.size(), 32'd0);
    check("q8_empty", q8.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor: difference = a - b, computed as a + ~b + 1.
- Processes one bit per clock through a single full-adder cell, LSB first. The carry register is initialised to 1, and operand b is inverted bit by bit.
- Serves as the area-minimal inverse of the parallel adder datapath. It feeds the ALU/test harness through a start/done handshake.

Parameters:
WIDTH, 4, operand and result width in bits (legal range 2..32)

Ports:
clk  input  1  single system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state on the next rising edge
start  input  1  request; sampled only when busy=0
a  input  WIDTH  minuend, captured on the accepted start edge
b  input  WIDTH  subtrahend, captured on the accepted start edge
busy  output  1  high while a subtraction is in progress
done  output  1  one-cycle pulse: result outputs newly valid
difference  output  WIDTH  a - b modulo 2^WIDTH
carryout  output  1  final carry of a + ~b + 1; 1 means no borrow (unsigned a >= b)
overflow  output  1  signed overflow: a[MSB] != b[MSB] and difference[MSB] != a[MSB]

Behaviour:
- Reset (synchronous, active-high; takes effect at the next rising edge when reset=1):
  - state = IDLE; busy=0, done=0, difference=0, carryout=0, overflow=0; bit counter=0; carry reg=1.
  - Reset has priority over start and over any in-flight operation.
  - Reset mid-RUN discards the operation; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0.
  - start=1 at an edge: latch a into the A shift reg and b into the B shift reg, set counter=0 and carry=1, go to RUN.
  - Result outputs keep their previous values until the new result is written.
- RUN:
  - busy=1.
  - At each edge: s = A[0] ^ ~B[0] ^ carry, and carry <= majority(A[0], ~B[0], carry).
  - s is shifted into the result register from the MSB side; A and B shift right; counter increments.
  - On the edge where counter == WIDTH-1, the last bit is processed and the FSM moves to DONE.
  - start is ignored while in RUN.
- DONE (exactly one cycle):
  - done=1, busy=0.
  - difference = assembled result register; carryout = final carry.
  - overflow = (a_msb ^ b_msb) & (a_msb ^ difference[MSB]), using MSBs captured at start.
  - Next edge: start=1 is accepted as a new request (back-to-back, same rules as IDLE); otherwise go to IDLE.
- Latency: start accepted at edge 0 -> busy high during cycles 1..WIDTH -> done high in cycle WIDTH+1. Throughput is one result per WIDTH+1 cycles.
- Output hold: difference, carryout and overflow are registered and stable from done until the next DONE state or reset. They never change during RUN.
- Operands:
  - Captured only at acceptance; changes on a/b afterwards have no effect.
  - a == b yields difference=0, carryout=1, overflow=0.
- Width rules:
  - Result wraps modulo 2^WIDTH.
  - The counter is ceil(log2(WIDTH)) bits and must not wrap before WIDTH-1.
- done and busy are never high in the same cycle.
- The single-bit cell uses the team's gate-level full adder with gate delays. The FSM and registers are behavioural.

Test Plan:
- Reset, then 5 - 3 (WIDTH=4): start at edge 0 -> busy cycles 1-4, done cycle 5; difference=4'b0010, carryout=1, overflow=0.
- 3 - 5 -> difference=4'b1110, carryout=0 (borrow), overflow=0.
- 4'b0111 - 4'b1111 (7 - (-1)) -> difference=4'b1000, carryout=0, overflow=1. Also 4'b1000 - 4'b0001 -> difference=4'b0111, carryout=1, overflow=1.
- Hold start=1 continuously with new operands (9 - 9, then 0 - 1):
  - done pulses every 5 cycles.
  - Second request is accepted in the DONE cycle; a/b changes during RUN are ignored.
  - Results: 0000/carryout=1, then 1111/carryout=0/overflow=0.
- Assert reset for one cycle during RUN cycle 2 of 6 - 2 -> all outputs 0 next cycle, no done pulse. A following 6 - 2 gives 0100, carryout=1.
- Exhaustive sweep of all 256 a/b pairs at WIDTH=4, plus randomised WIDTH=8 -> difference, carryout and overflow match the behavioural reference a - b on every done pulse.
